// File: rtl/mc_pkg.sv
// Shared definitions for the program-load path into the instruction memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

    // Instruction memory geometry, matching the four-port memory write port.
    localparam int IM_DEPTH  = 101;
    localparam int IM_ADDR_W = 16;
    localparam int IM_DATA_W = 16;

    // Loader frame-parsing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } im_state_e;

    // States in which a start pulse re-arms the loader and bytes are dropped.
    function automatic logic im_armable(input im_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle watchdog: loadable down-counter, expired once TIMEOUT idle clocks elapse.
// Latency: expired is combinational from the count; count updates one clock after load/en.
// Backpressure: none; load has priority over counting.
module byte_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // A load at edge e followed by TIMEOUT idle cycles reaches zero during the last one.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on every byte or arm, otherwise count down while enabled and saturate at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader: assembles little-endian words and writes them sequentially into instruction memory.
// Latency: write strobe, done and error all appear one clock after the deciding byte (or timeout).
// Backpressure: none; writes are naturally >= 2 clocks apart so the memory never stalls the stream.
module im_loader
    import mc_pkg::*;
#(
    parameter int DEPTH   = IM_DEPTH,
    parameter int TIMEOUT = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 im_write_en,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [IM_DATA_W-1:0] im_input_data,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_error,
    output logic [15:0]          word_count
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    im_state_e   state;
    logic [15:0] len;
    logic [7:0]  lo_byte;
    logic [7:0]  csum;
    logic        arm;
    logic        tmo_load;
    logic        tmo_en;
    logic        tmo_expired;
    logic [15:0] len_new;

    assign arm      = start && im_armable(state);
    assign tmo_load = rx_valid || arm;
    assign tmo_en   = !im_armable(state);
    assign len_new  = {rx_data, len[7:0]};

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Frame parser: length capture, word assembly/write, running XOR checksum and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            len           <= '0;
            lo_byte       <= '0;
            csum          <= '0;
            im_write_en   <= 1'b0;
            im_addr       <= '0;
            im_input_data <= '0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            word_count    <= '0;
        end else begin
            // Write strobe is a single-cycle pulse.
            im_write_en <= 1'b0;

            if (arm) begin
                // A byte coinciding with the arm pulse is dropped on purpose.
                state         <= ST_LEN_LO;
                len           <= '0;
                lo_byte       <= '0;
                csum          <= '0;
                im_addr       <= '0;
                im_input_data <= '0;
                word_count    <= '0;
                busy          <= 1'b1;
                load_done     <= 1'b0;
                load_error    <= 1'b0;
            end else if (!im_armable(state)) begin
                if (rx_valid) begin
                    case (state)
                        ST_LEN_LO: begin
                            len[7:0] <= rx_data;
                            state    <= ST_LEN_HI;
                        end
                        ST_LEN_HI: begin
                            len[15:8] <= rx_data;
                            if (len_new == 16'd0) begin
                                state <= ST_CHK;
                            end else if (len_new > DEPTH_W) begin
                                state      <= ST_ERR;
                                busy       <= 1'b0;
                                load_error <= 1'b1;
                            end else begin
                                state <= ST_DATA_LO;
                            end
                        end
                        ST_DATA_LO: begin
                            lo_byte <= rx_data;
                            csum    <= csum ^ rx_data;
                            state   <= ST_DATA_HI;
                        end
                        ST_DATA_HI: begin
                            // Next write address always equals the words written so far.
                            im_write_en   <= 1'b1;
                            im_addr       <= IM_ADDR_W'(word_count);
                            im_input_data <= {rx_data, lo_byte};
                            word_count    <= word_count + 16'd1;
                            csum          <= csum ^ rx_data;
                            if ((word_count + 16'd1) == len) begin
                                state <= ST_CHK;
                            end else begin
                                state <= ST_DATA_LO;
                            end
                        end
                        ST_CHK: begin
                            busy <= 1'b0;
                            if (rx_data == csum) begin
                                state     <= ST_DONE;
                                load_done <= 1'b1;
                            end else begin
                                state      <= ST_ERR;
                                load_error <= 1'b1;
                            end
                        end
                        default: begin
                            state <= state;
                        end
                    endcase
                end else if (tmo_expired) begin
                    // Stream stalled mid-frame; words already written are left in place.
                    state      <= ST_ERR;
                    busy       <= 1'b0;
                    load_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        im_write_en;
    logic [15:0] im_addr;
    logic [15:0] im_input_data;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [15:0] word_count;

    im_loader #(
        .DEPTH   (101),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .im_write_en   (im_write_en),
        .im_addr       (im_addr),
        .im_input_data (im_input_data),
        .busy          (busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_q[$];
    logic [15:0] tx_words[$];
    logic        prev_we = 1'b0;
    logic        we_adjacent = 1'b0;

    // Memory-side observer: every strobe captured as {addr, data}.
    always @(negedge clk) begin
        if (im_write_en) wr_q.push_back({im_addr, im_input_data});
        if (im_write_en && prev_we) we_adjacent = 1'b1;
        prev_we = im_write_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends one frame built from tx_words; chk_force: -1 correct, -2 corrupted, else literal value.
    task automatic load_verify(input string name, input int maxgap, input int chk_force);
        logic [7:0] chk_calc;
        logic [7:0] chk_sent;
        int         n;
        bit         exp_ok;
        @(negedge clk);
        wr_q.delete();
        n = tx_words.size();
        chk_calc = 8'h00;
        foreach (tx_words[i]) chk_calc = chk_calc ^ tx_words[i][7:0] ^ tx_words[i][15:8];
        if (chk_force == -1)      chk_sent = chk_calc;
        else if (chk_force == -2) chk_sent = chk_calc ^ 8'($urandom_range(255, 1));
        else                      chk_sent = 8'(chk_force);
        exp_ok = (chk_sent == chk_calc);

        do_start();
        total++;
        if (busy !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
            bad++;
            $display("FAIL %s armed: busy=%b done=%b err=%b want 1 0 0", name, busy, load_done, load_error);
        end

        send_byte(8'(n), $urandom_range(maxgap));
        send_byte(8'(n >> 8), $urandom_range(maxgap));
        foreach (tx_words[i]) begin
            send_byte(tx_words[i][7:0], $urandom_range(maxgap));
            send_byte(tx_words[i][15:8], $urandom_range(maxgap));
        end
        send_byte(chk_sent, 0);

        total++;
        if (load_done !== exp_ok || load_error !== !exp_ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s status: done=%b err=%b busy=%b want %b %b 0",
                     name, load_done, load_error, busy, exp_ok, !exp_ok);
        end
        total++;
        if (word_count !== 16'(n)) begin
            bad++;
            $display("FAIL %s word_count: got %0d want %0d", name, word_count, n);
        end
        total++;
        if (wr_q.size() != n) begin
            bad++;
            $display("FAIL %s write count: got %0d want %0d", name, wr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== {16'(i), tx_words[i]}) begin
                bad++;
                $display("FAIL %s wr[%0d]: got %h want %h", name, i, wr_q[i], {16'(i), tx_words[i]});
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if ({im_write_en, im_addr, im_input_data, busy, load_done, load_error, word_count} !== '0) begin
            bad++;
            $display("FAIL reset: we=%b addr=%h data=%h busy=%b done=%b err=%b wc=%h want all 0",
                     im_write_en, im_addr, im_input_data, busy, load_done, load_error, word_count);
        end
        rst_n = 1'b1;
        // Bytes in IDLE must be ignored.
        @(negedge clk);
        send_byte(8'h11, 1);
        total++;
        if (busy !== 1'b0 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL idle_byte: busy=%b writes=%0d want 0 0", busy, wr_q.size());
        end
    endtask

    task automatic test_normal();
        tx_words = '{16'h0003, 16'h0005, 16'h0007};
        load_verify("normal", 2, -1);
        // Bytes after DONE are discarded; status stays.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1);
        total++;
        if (wr_q.size() != 3 || word_count !== 16'd3 || load_done !== 1'b1) begin
            bad++;
            $display("FAIL after_done: writes=%0d wc=%0d done=%b want 3 3 1", wr_q.size(), word_count, load_done);
        end
    endtask

    task automatic test_zero_len();
        tx_words.delete();
        load_verify("zero_len", 1, -1);
    endtask

    task automatic test_oversize();
        @(negedge clk);
        wr_q.delete();
        do_start();
        send_byte(8'h66, 1);
        send_byte(8'h00, 0);
        total++;
        if (load_error !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL oversize: err=%b busy=%b done=%b want 1 0 0", load_error, busy, load_done);
        end
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        repeat (2) @(negedge clk);
        total++;
        if (wr_q.size() != 0 || word_count !== 16'd0 || load_error !== 1'b1) begin
            bad++;
            $display("FAIL oversize_ignore: writes=%0d wc=%0d err=%b want 0 0 1", wr_q.size(), word_count, load_error);
        end
    endtask

    task automatic test_bad_chk();
        tx_words = '{16'h002C};
        load_verify("bad_chk", 1, 8'hFF);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(12, 1);
            tx_words.delete();
            for (int i = 0; i < n; i++) tx_words.push_back(16'($urandom));
            load_verify($sformatf("random%0d", k), 3, (k % 2 == 1) ? -2 : -1);
        end
    endtask

    task automatic test_back_to_back();
        we_adjacent = 1'b0;
        tx_words.delete();
        for (int i = 0; i < 101; i++) tx_words.push_back(16'($urandom));
        load_verify("full_depth_b2b", 0, -1);
        total++;
        if (we_adjacent !== 1'b0) begin
            bad++;
            $display("FAIL write_spacing: adjacent strobes=%b want 0", we_adjacent);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        wr_q.delete();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        total++;
        if (load_error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: err=%b busy=%b want 0 1", load_error, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (load_error !== 1'b1 || busy !== 1'b0 || load_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout: err=%b busy=%b done=%b want 1 0 0", load_error, busy, load_done);
        end
        tx_words = '{16'(16'hA55A), 16'(16'h0102)};
        load_verify("after_timeout", 2, -1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_q.delete();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({im_write_en, im_addr, im_input_data, busy, load_done, load_error, word_count} !== '0) begin
            bad++;
            $display("FAIL reset_mid: we=%b addr=%h data=%h busy=%b done=%b err=%b wc=%h want all 0",
                     im_write_en, im_addr, im_input_data, busy, load_done, load_error, word_count);
        end
        @(negedge clk);
        send_byte(8'h12, 2);
        total++;
        if (wr_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_nowrite: writes=%0d busy=%b want 0 0", wr_q.size(), busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Start and a byte together in IDLE: the byte must not become LEN_LO.
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        send_byte(8'h66, 0);
        total++;
        if (load_done !== 1'b1 || word_count !== 16'd1 || wr_q.size() != 1) begin
            bad++;
            $display("FAIL start_with_byte: done=%b wc=%0d writes=%0d want 1 1 1", load_done, word_count, wr_q.size());
        end else begin
            total++;
            if (wr_q[0] !== 32'h0000_ABCD) begin
                bad++;
                $display("FAIL start_with_byte_wr: got %h want 0000abcd", wr_q[0]);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_normal();
        test_zero_len();
        test_oversize();
        test_bad_chk();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
